uart_alu_interface: RTL and testbench
=====================================

// Module: uart_alu_interface
// PURPOSE
//  Client-side endpoint of the UART link. Collects a 3-byte command frame from the UART
//  receiver (operand A, operand B, opcode), presents it on registered outputs to the
//  combinational ALU, captures the ALU result and hands it to the UART transmitter as
//  one response byte. Sits between the uart top (rx/tx byte ports) and the ALU.
// PARAMETERS
//  N_BITS          8         data/operand/result width; equals UART data width
//  NB_OP           6         opcode width; taken from opcode byte bits [NB_OP-1:0]
//  TIMEOUT_CYCLES  1000000   inter-byte timeout in i_clock cycles (UART_ALU_TIMEOUT_EN only)
// PORTS
//  i_clock          in   1       system clock
//  i_reset          in   1       synchronous, active-high reset
//  i_rx_done_tick   in   1       1-cycle pulse: byte received; i_rx_data valid this cycle
//  i_rx_data        in   N_BITS  received byte
//  i_tx_done_tick   in   1       1-cycle pulse: transmitter finished stop bit
//  i_alu_result     in   N_BITS  combinational ALU result for o_alu_a/b/op
//  o_alu_a          out  N_BITS  registered operand A
//  o_alu_b          out  N_BITS  registered operand B
//  o_alu_op         out  NB_OP   registered opcode
//  o_tx_start       out  1       1-cycle pulse: start transmission of o_tx_data
//  o_tx_data        out  N_BITS  response byte; held stable until next capture
//  o_busy           out  1       high in EXEC and WAIT_TX
//  o_overrun        out  1       1-cycle pulse: rx byte dropped while busy
//  o_timeout        out  1       1-cycle pulse: partial frame discarded (macro only)
// BEHAVIOUR
//  - Single clock i_clock; reset synchronous, active-high (i_reset). All outputs registered.
//  - Reset: state WAIT_A; o_alu_a=0, o_alu_b=0, o_alu_op=0, o_tx_data=0,
//    o_tx_start=0, o_busy=0, o_overrun=0, o_timeout=0. Reset mid-frame/mid-tx aborts silently.
//  - FSM: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> WAIT_TX -> WAIT_A.
//    WAIT_A : on i_rx_done_tick latch o_alu_a<=i_rx_data, -> WAIT_B.
//    WAIT_B : on i_rx_done_tick latch o_alu_b<=i_rx_data, -> WAIT_OP.
//    WAIT_OP: on i_rx_done_tick latch o_alu_op<=i_rx_data[NB_OP-1:0] (upper bits ignored), -> EXEC.
//    EXEC   : exactly 1 cycle (ALU settles on registered inputs); o_tx_data<=i_alu_result,
//             o_tx_start<=1 for the next cycle only, -> WAIT_TX.
//    WAIT_TX: o_tx_start=0; on i_tx_done_tick -> WAIT_A.
//  - Latency: op byte tick at cycle T -> o_alu_op valid T+1 (EXEC) -> o_tx_start=1 and
//    o_tx_data=result at T+2. Operands stay stable until overwritten by the next frame.
//  - Rx byte in EXEC or WAIT_TX: dropped, o_overrun pulses next cycle, operands unchanged.
//  - i_rx_done_tick and i_tx_done_tick same cycle in WAIT_TX: -> WAIT_A, byte dropped,
//    o_overrun pulses (byte is NOT taken as operand A).
//  - i_tx_done_tick outside WAIT_TX: ignored. No flow control toward the receiver.
// CONFIGURATION
//  - UART_ALU_TIMEOUT_EN defined: counter clears on every i_rx_done_tick and on entry to
//    WAIT_B; counts in WAIT_B/WAIT_OP only. Reaching TIMEOUT_CYCLES-1 with no byte ->
//    WAIT_A, o_timeout pulses 1 cycle, o_alu_* keep last values. Tick on the same cycle wins
//    (byte accepted, no timeout).
//  - Not defined: no counter instantiated; o_timeout tied 0; partial frames wait forever.
// STRUCTURE
//  - Shared package uart_alu_pkg: state encodings (WAIT_A..WAIT_TX, 3-bit), NB_OP default,
//    FRAME_BYTES=3, opcode constants shared with the ALU and the bench.
//  - One sub-module: byte_timeout_counter (clear, enable, expire pulse; width
//    $clog2(TIMEOUT_CYCLES)), instantiated only under UART_ALU_TIMEOUT_EN.
// TESTING
//  1 A=0x05,B=0x03,op=0x20 (ADD) -> o_alu_*=05/03/20, o_tx_start 1 pulse at T+2, o_tx_data=0x08.
//  2 Op byte 0xE2 -> o_alu_op=0x22; ALU SUB model 0x05-0x03 -> o_tx_data=0x02.
//  3 Extra byte 0x55 during WAIT_TX -> o_overrun 1 pulse, o_alu_a unchanged; next frame OK.
//  4 rx_done+tx_done same cycle in WAIT_TX -> state WAIT_A, o_overrun pulse, byte not used.
//  5 i_reset after A,B only -> all outputs 0, state WAIT_A; new full frame gives correct result.
//  6 Macro on, TIMEOUT_CYCLES=16: send A only, idle 16 cycles -> o_timeout pulse, WAIT_A;
//    macro off: same stimulus -> no pulse, next byte is taken as B.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU endpoint: FSM encodings, frame size and opcode values
// used by the interface, the ALU and the bench.
package uart_alu_pkg;

    localparam int NB_OP_DEF   = 6;
    localparam int FRAME_BYTES = 3;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

    function automatic logic is_busy_state(input state_t s);
        return (s == EXEC) || (s == WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_alu_interface_byte_timeout_counter.sv
// Inter-byte timeout counter: clears on request, counts while enabled, and flags expiry when
// the count sits at TIMEOUT_CYCLES-1 with counting enabled.
module byte_timeout_counter
#(
    parameter int TIMEOUT_CYCLES = 1000000
)
(
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, drives the ALU and returns one result byte.
// Optional inter-byte timeout is enabled by defining UART_ALU_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int N_BITS         = 8,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = 1000000
)
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx_done_tick,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_tx_done_tick,
    input  logic [N_BITS-1:0] i_alu_result,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [NB_OP-1:0]  o_alu_op,
    output logic              o_tx_start,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout,
    output logic [2:0]        o_dbg_state
);
    state_t              r_state;
    state_t              w_next_state;
    logic                w_overrun;
    logic                w_expire;
    logic [N_BITS-1:0]   r_alu_a;
    logic [N_BITS-1:0]   r_alu_b;
    logic [NB_OP-1:0]    r_alu_op;
    logic [N_BITS-1:0]   r_tx_data;
    logic                r_tx_start;
    logic                r_busy;
    logic                r_overrun;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A byte arriving with the timeout wins: the branch order below gives the tick priority.
    always_comb begin
        w_next_state = r_state;
        w_overrun    = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (i_rx_done_tick) w_next_state = WAIT_B;
            end
            WAIT_B: begin
                if (i_rx_done_tick) w_next_state = WAIT_OP;
                else if (w_expire)  w_next_state = WAIT_A;
            end
            WAIT_OP: begin
                if (i_rx_done_tick) w_next_state = EXEC;
                else if (w_expire)  w_next_state = WAIT_A;
            end
            EXEC: begin
                w_next_state = WAIT_TX;
                w_overrun    = i_rx_done_tick;
            end
            WAIT_TX: begin
                if (i_tx_done_tick) w_next_state = WAIT_A;
                w_overrun = i_rx_done_tick;
            end
            default: w_next_state = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_overrun  <= w_overrun;
            r_busy     <= is_busy_state(w_next_state);
            if (i_rx_done_tick && (r_state == WAIT_A))  r_alu_a  <= i_rx_data;
            if (i_rx_done_tick && (r_state == WAIT_B))  r_alu_b  <= i_rx_data;
            if (i_rx_done_tick && (r_state == WAIT_OP)) r_alu_op <= i_rx_data[NB_OP-1:0];
            if (r_state == EXEC) begin
                r_tx_data  <= i_alu_result;
                r_tx_start <= 1'b1;
            end
        end
    end

`ifdef UART_ALU_TIMEOUT_EN
    logic w_tmo_clear;
    logic w_tmo_enable;
    logic r_timeout;

    assign w_tmo_clear  = i_rx_done_tick || ((r_state != WAIT_B) && (w_next_state == WAIT_B));
    assign w_tmo_enable = (r_state == WAIT_B) || (r_state == WAIT_OP);

    byte_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire && !i_rx_done_tick;
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: frame capture, latency, opcode masking, overrun,
// simultaneous ticks, mid-frame reset and the optional inter-byte timeout.
module tb_uart_alu_interface;
    import uart_alu_pkg::*;

    localparam int N_BITS = 8;
    localparam int NB_OP  = 6;

    logic              clk;
    logic              rst;
    logic              rx_tick;
    logic [N_BITS-1:0] rx_data;
    logic              tx_tick;
    logic [N_BITS-1:0] alu_result;
    logic [N_BITS-1:0] alu_a;
    logic [N_BITS-1:0] alu_b;
    logic [NB_OP-1:0]  alu_op;
    logic              tx_start;
    logic [N_BITS-1:0] tx_data;
    logic              busy;
    logic              overrun;
    logic              timeout;
    logic [2:0]        dbg_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [N_BITS-1:0] exp_q[$];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    uart_alu_interface #(
        .N_BITS         (N_BITS),
        .NB_OP          (NB_OP),
`ifdef UART_ALU_TIMEOUT_EN
        .TIMEOUT_CYCLES (16)
`else
        .TIMEOUT_CYCLES (1000000)
`endif
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_rx_done_tick (rx_tick),
        .i_rx_data      (rx_data),
        .i_tx_done_tick (tx_tick),
        .i_alu_result   (alu_result),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_overrun      (overrun),
        .o_timeout      (timeout),
        .o_dbg_state    (dbg_state)
    );

    // Combinational ALU stand-in
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_NOR:  alu_result = ~(alu_a | alu_b);
            OP_SRA:  alu_result = $signed(alu_a) >>> alu_b[2:0];
            OP_SRL:  alu_result = alu_a >> alu_b[2:0];
            default: alu_result = '0;
        endcase
    end

    // Scoreboard: every response byte must match the next expected value
    always @(negedge clk) begin
        if (!rst && tx_start) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got tx_data=%h with nothing expected", tx_data);
            end else begin
                logic [N_BITS-1:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    tests_failed++;
                    $display("FAIL sb_tx_data: got %h expected %h", tx_data, e);
                end
            end
        end
    end

    // Driver tasks: inputs change on negedge, so each pulse spans exactly one posedge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [N_BITS-1:0] b);
        @(negedge clk);
        rx_tick = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_tick = 1'b0;
        rx_data = '0;
    endtask

    task automatic tx_done();
        @(negedge clk);
        tx_tick = 1'b1;
        @(negedge clk);
        tx_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b,
                              input logic [N_BITS-1:0] op, input logic [N_BITS-1:0] res);
        exp_q.push_back(res);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        @(negedge clk);
        tx_done();
    endtask

    task automatic check_all_zero(input string tag);
        tests_run++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout} !== '0) begin
            tests_failed++;
            $display("FAIL %s_outputs: got a=%h b=%h op=%h txd=%h st=%b busy=%b ovr=%b tmo=%b expected all 0",
                     tag, alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout);
        end
        tests_run++;
        if (dbg_state !== WAIT_A) begin
            tests_failed++;
            $display("FAIL %s_state: got %0d expected %0d", tag, dbg_state, WAIT_A);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        check_all_zero("reset");
    endtask

    task automatic test_add_latency();
        exp_q.push_back(8'h08);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        // one cycle after op tick: EXEC
        tests_run++;
        if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
            tests_failed++;
            $display("FAIL add_operands: got %h/%h/%h expected 05/03/20", alu_a, alu_b, alu_op);
        end
        tests_run++;
        if ({tx_start, busy, dbg_state} !== {1'b0, 1'b1, EXEC}) begin
            tests_failed++;
            $display("FAIL add_exec: got start=%b busy=%b state=%0d expected 0 1 %0d", tx_start, busy, dbg_state, EXEC);
        end
        @(negedge clk);
        tests_run++;
        if ({tx_start, tx_data, dbg_state} !== {1'b1, 8'h08, WAIT_TX}) begin
            tests_failed++;
            $display("FAIL add_t2: got start=%b data=%h state=%0d expected 1 08 %0d", tx_start, tx_data, dbg_state, WAIT_TX);
        end
        @(negedge clk);
        tests_run++;
        if ({tx_start, tx_data, busy} !== {1'b0, 8'h08, 1'b1}) begin
            tests_failed++;
            $display("FAIL add_t3: got start=%b data=%h busy=%b expected 0 08 1", tx_start, tx_data, busy);
        end
        tx_done();
        tests_run++;
        if ({busy, dbg_state} !== {1'b0, WAIT_A}) begin
            tests_failed++;
            $display("FAIL add_done: got busy=%b state=%0d expected 0 %0d", busy, dbg_state, WAIT_A);
        end
    endtask

    task automatic test_op_mask();
        send_frame(8'h05, 8'h03, 8'hE2, 8'h02);
        tests_run++;
        if (alu_op !== 6'h22) begin
            tests_failed++;
            $display("FAIL op_mask: got %h expected 22", alu_op);
        end
    endtask

    task automatic test_overrun();
        exp_q.push_back(8'h30);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h20);
        repeat (2) @(negedge clk);
        send_byte(8'h55);
        tests_run++;
        if ({overrun, alu_a, dbg_state} !== {1'b1, 8'h10, WAIT_TX}) begin
            tests_failed++;
            $display("FAIL ovr_pulse: got ovr=%b a=%h state=%0d expected 1 10 %0d", overrun, alu_a, dbg_state, WAIT_TX);
        end
        @(negedge clk);
        tests_run++;
        if (overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_width: got %b expected 0", overrun);
        end
        tx_done();
        send_frame(8'h07, 8'h02, 8'h22, 8'h05);
        tests_run++;
        if ({alu_a, alu_b} !== {8'h07, 8'h02}) begin
            tests_failed++;
            $display("FAIL ovr_next: got %h/%h expected 07/02", alu_a, alu_b);
        end
    endtask

    task automatic test_simul_ticks();
        exp_q.push_back(8'hE8);
        send_byte(8'hF0);
        send_byte(8'h08);
        send_byte(8'h22);
        repeat (2) @(negedge clk);
        rx_tick = 1'b1;
        rx_data = 8'h99;
        tx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        rx_data = '0;
        tx_tick = 1'b0;
        tests_run++;
        if ({dbg_state, overrun, alu_a, busy} !== {WAIT_A, 1'b1, 8'hF0, 1'b0}) begin
            tests_failed++;
            $display("FAIL simul: got state=%0d ovr=%b a=%h busy=%b expected %0d 1 f0 0", dbg_state, overrun, alu_a, busy, WAIT_A);
        end
        send_frame(8'h0A, 8'h0B, 8'h24, 8'h0A);
        tests_run++;
        if ({alu_a, alu_b, alu_op} !== {8'h0A, 8'h0B, 6'h24}) begin
            tests_failed++;
            $display("FAIL simul_next: got %h/%h/%h expected 0a/0b/24", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset();
        check_all_zero("midreset");
        send_frame(8'h09, 8'h04, 8'h20, 8'h0D);
        tests_run++;
        if ({alu_a, alu_b} !== {8'h09, 8'h04}) begin
            tests_failed++;
            $display("FAIL midreset_next: got %h/%h expected 09/04", alu_a, alu_b);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'h33);
`ifdef UART_ALU_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                tests_run++;
                if ({timeout, dbg_state} !== {1'b0, WAIT_B}) begin
                    tests_failed++;
                    $display("FAIL tmo_early_%0d: got tmo=%b state=%0d expected 0 %0d", i, timeout, dbg_state, WAIT_B);
                end
            end
        end
        tests_run++;
        if ({timeout, dbg_state, alu_a} !== {1'b1, WAIT_A, 8'h33}) begin
            tests_failed++;
            $display("FAIL tmo_fire: got tmo=%b state=%0d a=%h expected 1 %0d 33", timeout, dbg_state, alu_a, WAIT_A);
        end
        @(negedge clk);
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_width: got %b expected 0", timeout);
        end
        send_frame(8'h01, 8'h02, 8'h20, 8'h03);
`else
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (timeout !== 1'b0) seen++;
            end
            tests_run++;
            if (seen != 0) begin
                tests_failed++;
                $display("FAIL tmo_off: got %0d timeout cycles expected 0", seen);
            end
        end
        send_byte(8'h04);
        tests_run++;
        if ({dbg_state, alu_b} !== {WAIT_OP, 8'h04}) begin
            tests_failed++;
            $display("FAIL tmo_off_b: got state=%0d b=%h expected %0d 04", dbg_state, alu_b, WAIT_OP);
        end
        exp_q.push_back(8'h37);
        send_byte(8'h20);
        @(negedge clk);
        tx_done();
`endif
    endtask

    initial begin
        rst     = 1'b1;
        rx_tick = 1'b0;
        rx_data = '0;
        tx_tick = 1'b0;
        test_reset();
        test_add_latency();
        test_op_mask();
        test_overrun();
        test_simul_ticks();
        test_reset_midframe();
        test_timeout();
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d pending responses expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
